// File: rtl/reg_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: destination mode
// encodings, fixed register numbers and the sequencer state type.
package reg_write_pkg;

  localparam logic [2:0] MODE_RT  = 3'b000;
  localparam logic [2:0] MODE_RD  = 3'b001;
  localparam logic [2:0] MODE_RS  = 3'b010;
  localparam logic [2:0] MODE_RA  = 3'b011;
  localparam logic [2:0] MODE_SP  = 3'b100;
  localparam logic [2:0] MODE_DBG = 3'b111;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_SP = 5'd29;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIM,
    S_SP2,
    S_DBG
  } state_t;

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Bus bundle for reg_write_sequencer: primary and debug request channels,
// error control, and the registered register-file write port.
// Optional forwarding signals are present when REG_WRITE_SEQ_FWD_EN is defined.
interface reg_write_sequencer_if #(
  parameter int DATA_W = 32
) ();

  logic              prim_valid;
  logic              prim_ready;
  logic [2:0]        prim_mode;
  logic [4:0]        prim_rt;
  logic [4:0]        prim_rd;
  logic [4:0]        prim_rs;
  logic [DATA_W-1:0] prim_data;
  logic              prim_dual;
  logic [DATA_W-1:0] prim_sp_data;

  logic              dbg_valid;
  logic              dbg_ready;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  logic              err_clr;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        wr_sel;
  logic              busy;
  logic              err_illegal;

`ifdef REG_WRITE_SEQ_FWD_EN
  logic [4:0]        fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Requester / environment side
  modport master (
    output prim_valid, prim_mode, prim_rt, prim_rd, prim_rs, prim_data,
           prim_dual, prim_sp_data, dbg_valid, dbg_addr, dbg_data, err_clr,
`ifdef REG_WRITE_SEQ_FWD_EN
           fwd_raddr,
    input  fwd_hit, fwd_data,
`endif
    input  prim_ready, dbg_ready, rf_we, rf_waddr, rf_wdata, wr_sel, busy,
           err_illegal
  );

  // Sequencer side
  modport slave (
    input  prim_valid, prim_mode, prim_rt, prim_rd, prim_rs, prim_data,
           prim_dual, prim_sp_data, dbg_valid, dbg_addr, dbg_data, err_clr,
`ifdef REG_WRITE_SEQ_FWD_EN
           fwd_raddr,
    output fwd_hit, fwd_data,
`endif
    output prim_ready, dbg_ready, rf_we, rf_waddr, rf_wdata, wr_sel, busy,
           err_illegal
  );

endinterface

// File: rtl/reg_write_dst_decode.sv
// Destination decode: maps a primary write mode and the instruction register
// fields to a 5-bit register address, flagging the unused mode encodings.
module reg_write_dst_decode
  import reg_write_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  output logic [4:0] addr,
  output logic       illegal
);

  // Pure mode-to-address mapping; illegal modes yield address 0
  always_comb begin
    addr    = '0;
    illegal = 1'b0;
    case (mode)
      MODE_RT: addr = rt;
      MODE_RD: addr = rd;
      MODE_RS: addr = rs;
      MODE_RA: addr = REG_RA;
      MODE_SP: addr = REG_SP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_write_sequencer.sv
// Register-file write port owner for the multicycle MIPS datapath.
// Arbitrates the primary writeback channel against a debug/host channel with
// a starvation limit on debug, and splits dual writes (destination plus $29)
// into two back-to-back port writes. All port outputs are registered.
// Optional feature macro: REG_WRITE_SEQ_FWD_EN adds a write-port forwarding
// lookup (fwd_raddr / fwd_hit / fwd_data).
module reg_write_sequencer
  import reg_write_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_write_sequencer_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic              lat_dual, dual_nxt;
  logic              lat_illegal, ill_nxt;
  logic [DATA_W-1:0] lat_sp_data, sp_nxt;
  logic [3:0]        cnt, cnt_nxt;

  logic              we_q, we_nxt;
  logic [4:0]        waddr_q, waddr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [2:0]        sel_q, sel_nxt;
  logic              busy_q, busy_nxt;
  logic              err_q, err_nxt;

  logic              accept_cap;
  logic              prim_grant;
  logic              dbg_grant;
  logic [4:0]        dec_addr;
  logic              dec_illegal;

  reg_write_dst_decode u_dst_decode (
    .mode    (bus.prim_mode),
    .rt      (bus.prim_rt),
    .rd      (bus.prim_rd),
    .rs      (bus.prim_rs),
    .addr    (dec_addr),
    .illegal (dec_illegal)
  );

  // Arbitration: only the second half of a dual op blocks new requests
  always_comb begin
    accept_cap = !(state == S_PRIM && lat_dual);
    prim_grant = accept_cap && bus.prim_valid &&
                 !(bus.dbg_valid && cnt == LIMIT);
    dbg_grant  = accept_cap && !prim_grant && bus.dbg_valid;
  end

  assign bus.prim_ready  = prim_grant;
  assign bus.dbg_ready   = dbg_grant;
  assign bus.rf_we       = we_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.wr_sel      = sel_q;
  assign bus.busy        = busy_q;
  assign bus.err_illegal = err_q;

  // Next state and next registered outputs; write fields are computed here so
  // the port reflects an accepted request in the very next cycle
  always_comb begin
    state_nxt = S_IDLE;
    we_nxt    = 1'b0;
    waddr_nxt = waddr_q;
    wdata_nxt = wdata_q;
    sel_nxt   = sel_q;
    busy_nxt  = 1'b0;
    dual_nxt  = 1'b0;
    ill_nxt   = 1'b0;
    sp_nxt    = lat_sp_data;

    if (!accept_cap) begin
      state_nxt = S_SP2;
      we_nxt    = 1'b1;
      waddr_nxt = REG_SP;
      wdata_nxt = lat_sp_data;
      sel_nxt   = MODE_SP;
    end else if (prim_grant) begin
      state_nxt = S_PRIM;
      we_nxt    = !dec_illegal && (dec_addr != 5'd0);
      waddr_nxt = dec_addr;
      wdata_nxt = bus.prim_data;
      sel_nxt   = bus.prim_mode;
      dual_nxt  = bus.prim_dual && !dec_illegal;
      busy_nxt  = bus.prim_dual && !dec_illegal;
      ill_nxt   = dec_illegal;
      sp_nxt    = bus.prim_sp_data;
    end else if (dbg_grant) begin
      state_nxt = S_DBG;
      we_nxt    = (bus.dbg_addr != 5'd0);
      waddr_nxt = bus.dbg_addr;
      wdata_nxt = bus.dbg_data;
      sel_nxt   = MODE_DBG;
    end

    // Error flag is raised one edge after the illegal request is accepted;
    // a coincident set overrides the clear
    err_nxt = err_q;
    if (bus.err_clr)
      err_nxt = 1'b0;
    if (state == S_PRIM && lat_illegal)
      err_nxt = 1'b1;

    cnt_nxt = cnt;
    if (!bus.dbg_valid || dbg_grant)
      cnt_nxt = '0;
    else if (prim_grant && cnt < LIMIT)
      cnt_nxt = cnt + 4'd1;
  end

  // State register and registered outputs; reset drops any pending $29 write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      lat_dual    <= 1'b0;
      lat_illegal <= 1'b0;
      lat_sp_data <= '0;
      cnt         <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_dual    <= dual_nxt;
      lat_illegal <= ill_nxt;
      lat_sp_data <= sp_nxt;
      cnt         <= cnt_nxt;
      we_q        <= we_nxt;
      waddr_q     <= waddr_nxt;
      wdata_q     <= wdata_nxt;
      sel_q       <= sel_nxt;
      busy_q      <= busy_nxt;
      err_q       <= err_nxt;
    end
  end

`ifdef REG_WRITE_SEQ_FWD_EN
  // Forwarding lookup against the write currently presented on the port
  always_comb begin
    bus.fwd_hit  = we_q && (waddr_q == bus.fwd_raddr) && (bus.fwd_raddr != 5'd0);
    bus.fwd_data = bus.fwd_hit ? wdata_q : '0;
  end
`endif

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed self-checking bench for reg_write_sequencer (STARVE_LIMIT=4).
module tb_reg_write_sequencer;

  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  reg_write_sequencer_if #(.DATA_W(DATA_W)) bus ();

  reg_write_sequencer #(
    .STARVE_LIMIT (4),
    .DATA_W       (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [2:0] sel);
    chk({tag, "_we"},    32'(bus.rf_we),    32'(we));
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(wa));
    chk({tag, "_wdata"}, bus.rf_wdata,      wd);
    chk({tag, "_sel"},   32'(bus.wr_sel),   32'(sel));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.prim_valid   = 1'b0;
    bus.prim_mode    = 3'b000;
    bus.prim_rt      = 5'd0;
    bus.prim_rd      = 5'd0;
    bus.prim_rs      = 5'd0;
    bus.prim_data    = '0;
    bus.prim_dual    = 1'b0;
    bus.prim_sp_data = '0;
    bus.dbg_valid    = 1'b0;
    bus.dbg_addr     = 5'd0;
    bus.dbg_data     = '0;
    bus.err_clr      = 1'b0;
`ifdef REG_WRITE_SEQ_FWD_EN
    bus.fwd_raddr    = 5'd0;
`endif

    // Reset state
    #12;
    chk_port("rst", 1'b0, 5'd0, 32'h0, 3'b000);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_illegal), 32'd0);
    chk("rst_pready", 32'(bus.prim_ready), 32'd0);
    reset = 1'b1;
    tick();

    // Primary single write rd=8
    bus.prim_valid = 1'b1; bus.prim_mode = 3'b001;
    bus.prim_rt = 5'd3; bus.prim_rd = 5'd8; bus.prim_rs = 5'd5;
    bus.prim_data = 32'hDEADBEEF; bus.prim_dual = 1'b0;
    #1 chk("p1_ready", 32'(bus.prim_ready), 32'd1);
    tick();
    chk_port("p1", 1'b1, 5'd8, 32'hDEADBEEF, 3'b001);
    chk("p1_busy", 32'(bus.busy), 32'd0);

    // Dual write rt=4 <- 0x11, then $29 <- 0x7FFC
    bus.prim_mode = 3'b000; bus.prim_rt = 5'd4; bus.prim_data = 32'h11;
    bus.prim_dual = 1'b1; bus.prim_sp_data = 32'h7FFC;
    #1 chk("d_ready", 32'(bus.prim_ready), 32'd1);
    tick();
    chk_port("d1", 1'b1, 5'd4, 32'h11, 3'b000);
    chk("d1_busy", 32'(bus.busy), 32'd1);
    // a new request waits while the $29 write is pending
    bus.prim_mode = 3'b001; bus.prim_rd = 5'd9; bus.prim_data = 32'h55;
    bus.prim_dual = 1'b0;
    #1 chk("d1_pready", 32'(bus.prim_ready), 32'd0);
    tick();
    chk_port("d2", 1'b1, 5'd29, 32'h7FFC, 3'b100);
    chk("d2_busy", 32'(bus.busy), 32'd0);
    #1 chk("d2_pready", 32'(bus.prim_ready), 32'd1);
    tick();
    chk_port("p9", 1'b1, 5'd9, 32'h55, 3'b001);
`ifdef REG_WRITE_SEQ_FWD_EN
    bus.fwd_raddr = 5'd9;
    #1 chk("fwd_hit9", 32'(bus.fwd_hit), 32'd1);
    chk("fwd_data9", bus.fwd_data, 32'h55);
    bus.fwd_raddr = 5'd0;
    #1 chk("fwd_hit0", 32'(bus.fwd_hit), 32'd0);
    chk("fwd_data0", bus.fwd_data, 32'h0);
`endif

    // Write to $0: accepted, no write enable
    bus.prim_mode = 3'b000; bus.prim_rt = 5'd0; bus.prim_data = 32'h1234;
    #1 chk("z_ready", 32'(bus.prim_ready), 32'd1);
    tick();
    chk_port("z", 1'b0, 5'd0, 32'h1234, 3'b000);

    // Illegal mode with dual set: dual ignored, error one edge later
    bus.prim_mode = 3'b110; bus.prim_dual = 1'b1; bus.prim_data = 32'hAA;
    #1 chk("il_ready", 32'(bus.prim_ready), 32'd1);
    tick();
    bus.prim_valid = 1'b0; bus.prim_dual = 1'b0;
    chk("il_we", 32'(bus.rf_we), 32'd0);
    chk("il_busy", 32'(bus.busy), 32'd0);
    chk("il_err_early", 32'(bus.err_illegal), 32'd0);
    tick();
    chk("il_err", 32'(bus.err_illegal), 32'd1);
    chk("il_we2", 32'(bus.rf_we), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    chk("il_clr", 32'(bus.err_illegal), 32'd0);
    // set and clear on the same edge: set wins
    bus.prim_valid = 1'b1; bus.prim_mode = 3'b101;
    tick();
    bus.prim_valid = 1'b0;
    tick();
    chk("il_setwins", 32'(bus.err_illegal), 32'd1);
    tick();
    chk("il_clr2", 32'(bus.err_illegal), 32'd0);
    bus.err_clr = 1'b0;

    // Debug writes, including to $0
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_data = 32'hCAFE;
    #1 chk("g_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    chk_port("g", 1'b1, 5'd12, 32'hCAFE, 3'b111);
    bus.dbg_addr = 5'd0; bus.dbg_data = 32'hBEEF;
    tick();
    chk_port("g0", 1'b0, 5'd0, 32'hBEEF, 3'b111);
    bus.dbg_valid = 1'b0;
    tick();
    chk("g_idle_we", 32'(bus.rf_we), 32'd0);

    // Starvation: both requesters held, 4 primary grants then one debug
    bus.prim_valid = 1'b1; bus.prim_mode = 3'b001; bus.prim_rd = 5'd7;
    bus.prim_data = 32'h1;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_data = 32'h2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        #1 chk("sv_pready", 32'(bus.prim_ready), 32'd1);
        chk("sv_dready0", 32'(bus.dbg_ready), 32'd0);
        tick();
        chk("sv_psel", 32'(bus.wr_sel), 32'(3'b001));
      end
      #1 chk("sv_dready", 32'(bus.dbg_ready), 32'd1);
      chk("sv_pready0", 32'(bus.prim_ready), 32'd0);
      tick();
      chk_port("sv_dbg", 1'b1, 5'd3, 32'h2, 3'b111);
    end
    bus.dbg_valid = 1'b0;

    // Reset between the two halves of a dual write
    bus.prim_rd = 5'd10; bus.prim_data = 32'h77; bus.prim_dual = 1'b1;
    bus.prim_sp_data = 32'h1000;
    tick();
    chk_port("r1", 1'b1, 5'd10, 32'h77, 3'b001);
    chk("r1_busy", 32'(bus.busy), 32'd1);
    bus.prim_valid = 1'b0; bus.prim_dual = 1'b0;
    #2 reset = 1'b0;
    #1 chk_port("r_async", 1'b0, 5'd0, 32'h0, 3'b000);
    chk("r_async_busy", 32'(bus.busy), 32'd0);
    #3 reset = 1'b1;
    tick();
    chk_port("r_post1", 1'b0, 5'd0, 32'h0, 3'b000);
    tick();
    chk_port("r_post2", 1'b0, 5'd0, 32'h0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Owns the single register-file write port and generates the write-register select for the multicycle MIPS datapath.
- Arbitrates two requesters: the primary writeback channel from the control unit, and a debug/host write channel.
- Sequences dual-write operations (stack push/pop: destination register plus $29 update) as two back-to-back port writes.
- Sits between the control FSM and the register bank; all port outputs are registered.

Parameters:
- STARVE_LIMIT, 4: consecutive primary grants allowed while a debug request waits before debug is forced through (1..15).
- DATA_W, 32: register data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- prim_valid  in  1  primary write request valid.
- prim_ready  out  1  primary request accepted this cycle.
- prim_mode  in  3  destination mode: 000 rt, 001 rd, 010 rs, 011 $31, 100 $29, 101-111 illegal.
- prim_rt / prim_rd / prim_rs  in  5 each  instruction register fields.
- prim_data  in  DATA_W  data for the destination register.
- prim_dual  in  1  also write $29 with prim_sp_data in the following cycle.
- prim_sp_data  in  DATA_W  new stack pointer value.
- dbg_valid  in  1  debug write request valid.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  DATA_W  debug write data.
- err_clr  in  1  clears err_illegal.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  DATA_W  write data.
- wr_sel  out  3  mirror of the selected mode (debug writes drive 111).
- busy  out  1  high while a dual write is pending.
- err_illegal  out  1  sticky flag: an illegal mode was accepted.

Behaviour:
- Reset values: state S_IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wr_sel=000, busy=0, err_illegal=0, starve counter=0. Outputs clear immediately on assertion of reset.
- Reset mid-operation drops any pending $29 write; the request is not retried.
- States and what each drives:
  - S_IDLE: no write.
  - S_PRIM: primary write.
  - S_SP2: $29 write of a dual operation.
  - S_DBG: debug write.
- Accept-capable states: S_IDLE, S_DBG, S_SP2, and S_PRIM when the latched request is not dual.
- In S_PRIM with dual latched: both readies are 0, busy=1, next state is S_SP2.
- Arbitration, evaluated in accept-capable states only:
  - Primary is granted if prim_valid and not (dbg_valid and cnt==STARVE_LIMIT).
  - Otherwise debug is granted if dbg_valid.
  - Ready is combinational and asserted only for the granted requester.
  - A handshake completes on valid&ready. Request fields are latched on that edge.
- Next state: primary grant goes to S_PRIM, debug grant to S_DBG, no grant to S_IDLE.
- Latency: a request accepted on edge N has rf_we=1 in the cycle after edge N. Throughput is one write per cycle; a dual op takes two cycles.
- Address decode: 011 selects 31, 100 selects 29, otherwise the chosen field. The S_SP2 write uses address 29 and the latched prim_sp_data, with wr_sel=100.
- Address 0: rf_we is held 0 for any write to $0, whether primary or debug. The handshake still completes normally.
- Illegal mode: the request is accepted and rf_we stays 0. err_illegal is set on the following edge, and a latched dual flag is ignored.
- err_illegal is cleared by err_clr. If set and clear coincide, set wins.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each primary grant while dbg_valid=1.
  - Clears on a debug grant or whenever dbg_valid=0.

Optional Feature:
- Macro REG_WRITE_SEQ_FWD_EN.
- With the macro defined, the block adds three ports:
  - fwd_raddr  in  5
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- fwd_hit=1 when rf_we=1 and rf_waddr==fwd_raddr and fwd_raddr!=0. fwd_data equals rf_wdata when hit, otherwise 0. The logic is combinational from the registered outputs.
- Without the macro, these ports and the logic are absent.

Decomposition:
- Package reg_write_pkg holds:
  - mode constants (MODE_RT..MODE_SP, MODE_DBG=3'b111);
  - REG_RA=31, REG_SP=29;
  - the state enum.
- Sub-module reg_write_dst_decode: combinational mapping of mode and the rt/rd/rs fields to a 5-bit address plus an illegal flag.

Test Plan:
- Primary write: prim mode=001, rd=8, data=0xDEADBEEF → the next cycle shows rf_we=1, waddr=8, wdata=0xDEADBEEF, wr_sel=001.
- Dual write: mode=000, rt=4, data=0x11, dual=1, sp_data=0x7FFC:
  - Cycle 1 writes 4←0x11, and prim_ready=0 while busy=1.
  - Cycle 2 writes 29←0x7FFC.
- Starvation: prim_valid and dbg_valid held continuously with STARVE_LIMIT=4 → four primary grants, then dbg_ready=1, then the pattern repeats.
- $0 and illegal mode:
  - mode=000, rt=0 → accepted with rf_we=0.
  - mode=110 → rf_we=0 and err_illegal=1; err_clr returns it to 0.
- Reset between the two writes of a dual op: reset asserted asynchronously while in S_PRIM with dual latched → rf_we drops at once and no $29 write occurs after release.
- With REG_WRITE_SEQ_FWD_EN: during the write 9←0x55, fwd_raddr=9 gives fwd_hit=1 and fwd_data=0x55; fwd_raddr=0 gives fwd_hit=0.
